fifo_rd_packer: RTL
===================

# fifo_rd_packer

Read-side consumer for the team's asynchronous FIFO, sitting in the read clock domain on the FIFO's read port. It pops `width`-bit entries using the FIFO's `EMPTY`/`R_INC` handshake and packs `PACK` consecutive entries, little-endian, into one wide output word. It presents that word on a valid/ready stream. A `FLUSH` request emits a partially filled word together with a lane mask, so trailing data is never stranded.

## Interface
- `width`, 8: FIFO entry width in bits; matches the FIFO's data width.
- `PACK`, 2: entries per output word; must be at least 2.
- `R_CLK`, input, 1: read-domain clock; all logic is on the rising edge.
- `R_RST`, input, 1: synchronous, active-high reset.
- `EMPTY`, input, 1: FIFO empty flag. While low, `RD_DATA` holds the head entry.
- `RD_DATA`, input, `width`: FIFO head entry.
- `R_INC`, output, 1: FIFO pop. The head is consumed on any rising edge where this is 1.
- `FLUSH`, input, 1: single-cycle request to emit the partial word.
- `OUT_READY`, input, 1: downstream accept.
- `OUT_VALID`, output, 1: output word valid.
- `OUT_DATA`, output, `width*PACK`: packed word. Lane i is bits `[i*width +: width]`, and lane 0 holds the oldest entry.
- `OUT_KEEP`, output, `PACK`: lane-valid mask. Bit i is 1 when lane i holds real data.

## Operation
- **Internal state:**
  - assembly register `acc` (`width*PACK` bits);
  - lane index `idx` (`$clog2(PACK)` bits);
  - output register (`OUT_DATA`, `OUT_KEEP`, `OUT_VALID`);
  - flush-pending flag `fp`.
- **Output free, `ofree`:** `!OUT_VALID || OUT_READY`.
- **Pop rule:** `R_INC = !R_RST && !EMPTY && !fp && !FLUSH && !(idx==PACK-1 && !ofree)`.
  - `R_INC` is combinational from `EMPTY`, `FLUSH`, `OUT_READY` and registered state.
- **On a pop:**
  - `RD_DATA` is written into lane `idx` of `acc`.
  - If `idx < PACK-1`: `idx` is incremented.
  - If `idx == PACK-1`: the output register is loaded with `acc` including the new lane, `OUT_KEEP` is set to all ones, `OUT_VALID` is set to 1, `idx` is set to 0, and `acc` is cleared.
- **FSM states:** ACCUM (`fp=0`) and FLUSH_WAIT (`fp=1`).
- **ACCUM, `FLUSH=1` and `idx==0`:** no effect; the request is dropped.
- **ACCUM, `FLUSH=1`, `idx>0` and `ofree`:**
  - The output register is loaded with `acc`; unfilled lanes are zero.
  - `OUT_KEEP` is set to `(1<<idx)-1`, `OUT_VALID` to 1, `idx` to 0, and `acc` is cleared.
  - The FSM stays in ACCUM.
- **ACCUM, `FLUSH=1`, `idx>0` and not `ofree`:** go to FLUSH_WAIT; popping stops.
- **FLUSH_WAIT:** on the first cycle with `ofree`, perform the partial load above and return to ACCUM.
  - A `FLUSH` asserted while already in FLUSH_WAIT is absorbed.
- **Output handshake:**
  - A word transfers on an edge where `OUT_VALID && OUT_READY`.
  - If no new load occurs on that edge, `OUT_VALID` goes to 0. `OUT_DATA` and `OUT_KEEP` keep their last value.
  - While `OUT_VALID=1` and `OUT_READY=0`, `OUT_DATA`, `OUT_KEEP` and `OUT_VALID` hold stable.
- **Simultaneous events:** a transfer and a new load on the same edge are both honored; `OUT_VALID` stays 1 with the new word.

## Timing
- **Reset values:** `OUT_VALID=0`, `OUT_DATA=0`, `OUT_KEEP=0`, `R_INC=0`.
  - Internally, `idx=0`, `acc=0` and FSM state ACCUM.
- **Reset mid-operation:** `R_RST` asserted mid-word discards `acc`, any pending flush and any held output word on that edge.
  - No pop occurs during a reset cycle.
- **Latency:** `OUT_VALID` rises one edge after the pop of the last lane.
  - For a flush, it rises one edge after the cycle the flush executes.
- **Throughput:** with `EMPTY=0` and `OUT_READY=1` held, one pop every cycle and one output word every `PACK` cycles, with no bubbles.
- **Backpressure:** when `OUT_READY=0` with a full output, lanes 0 to `PACK-2` still fill; the last-lane pop waits.
- **FIFO empty:** while `EMPTY=1`, nothing is popped and `idx` holds. No timeout; only `FLUSH` emits a partial word.

## Structure
- **Shared package:** `lane_keep(idx)`, the function producing `(1<<idx)-1`, and the FSM state encoding (ACCUM=0, FLUSH_WAIT=1).
- **Sub-module `fifo_out_reg`:** the output register with its valid/ready hold logic. It is reusable by other read-side blocks.
- **Top level:** pack/flush FSM, `idx` counter and pop logic.

## Test plan
1. **Reset:** hold `R_RST=1` for 3 cycles with `EMPTY=0` → `R_INC=0`, `OUT_VALID=0`, `OUT_DATA=0`, `OUT_KEEP=0` throughout.
2. **Streaming:** FIFO holds AA, BC, 6F, FF; `OUT_READY=1` → words `16'hBCAA` then `16'hFF6F` with `OUT_KEEP=2'b11`. Exactly 4 `R_INC` pulses, after which `EMPTY` rises.
3. **Partial flush:** pop A5 only, then `FLUSH` pulse → `OUT_DATA=16'h00A5`, `OUT_KEEP=2'b01`; next word starts at lane 0.
4. **Backpressure:** `OUT_READY=0` with `OUT_VALID=1` holding `16'hC3A5`; FIFO holds 32, FF → exactly one pop (32) and the output stays stable. Raising `OUT_READY` gives `16'hC3A5`, then `16'hFF32` one edge later.
5. **Flush wait:** `FLUSH` issued while the output is stalled and `idx=1` → no pops during FLUSH_WAIT; the partial word emits with `OUT_KEEP=2'b01` on the first `ofree` cycle. A `FLUSH` at `idx=0` produces no output.
6. **Reset mid-word:** after a single pop of 92, assert `R_RST` for 1 cycle, then stream D7, 55 → the output is `16'h55D7`; 92 never appears.

Source files
------------

// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer and related read-side blocks.
//   state_e   : pack/flush FSM encoding (accumulate / waiting to emit a partial word)
//   lane_keep : lane-valid mask for a word holding the first idx lanes
package fifo_rd_packer_pkg;

  typedef enum logic [0:0] {
    StAccum     = 1'b0,
    StFlushWait = 1'b1
  } state_e;

  // Widest lane mask lane_keep can produce.
  localparam int unsigned MaxLanes = 32;

  // Returns (1 << idx) - 1, i.e. the low idx lanes marked valid.
  function automatic logic [MaxLanes-1:0] lane_keep(input int unsigned idx);
    logic [MaxLanes:0] one_hot;
    logic [MaxLanes:0] mask;
    one_hot = '0;
    if (idx <= MaxLanes) begin
      one_hot[idx] = 1'b1;
    end
    mask = one_hot - (MaxLanes + 1)'(1);
    return mask[MaxLanes-1:0];
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Output register with valid/ready hold logic for read-side stream producers.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   load_i  : capture data_i/keep_i and assert valid_o this edge
//   data_i  : word to load
//   keep_i  : lane mask to load
//   ready_i : downstream accept
//   valid_o : word valid
//   data_o  : held word (keeps its last value after a transfer)
//   keep_o  : held lane mask (keeps its last value after a transfer)
module fifo_out_reg #(
  parameter int unsigned DataW = 16,
  parameter int unsigned KeepW = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic [KeepW-1:0] keep_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [KeepW-1:0] keep_o
);

  logic             valid_q, valid_d;
  logic [DataW-1:0] data_q, data_d;
  logic [KeepW-1:0] keep_q, keep_d;

  // A load may coincide with a transfer of the current word; the load wins and
  // valid stays high. Callers only load when the register is free.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      keep_d  = keep_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer for the asynchronous FIFO: pops entries and packs PACK of
// them, little-endian (lane 0 oldest), into one output word on a valid/ready
// stream. FLUSH emits a partially filled word with a lane mask.
// Ports:
//   R_CLK     : read-domain clock, rising edge
//   R_RST     : synchronous active-high reset
//   EMPTY     : FIFO empty flag; RD_DATA is the head entry while low
//   RD_DATA   : FIFO head entry
//   R_INC     : FIFO pop (combinational)
//   FLUSH     : single-cycle request to emit the partial word
//   OUT_READY : downstream accept
//   OUT_VALID : output word valid
//   OUT_DATA  : packed word, lane i at [i*width +: width]
//   OUT_KEEP  : lane-valid mask
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned PACK  = 2
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EMPTY,
  input  logic [width-1:0]      RD_DATA,
  output logic                  R_INC,
  input  logic                  FLUSH,
  input  logic                  OUT_READY,
  output logic                  OUT_VALID,
  output logic [width*PACK-1:0] OUT_DATA,
  output logic [PACK-1:0]       OUT_KEEP
);

  localparam int unsigned     IdxW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned     DataW   = width * PACK;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PACK - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DataW-1:0]  acc_q, acc_d;
  logic [DataW-1:0]  acc_wr;
  logic              ofree;
  logic              last_lane;
  logic              flush_go;
  logic              load;
  logic [DataW-1:0]  load_data;
  logic [PACK-1:0]   load_keep;
  logic [MaxLanes-1:0] keep_partial;

  assign ofree     = !OUT_VALID || OUT_READY;
  assign last_lane = (idx_q == LastIdx);

  // The last lane may only be popped when the output register can take the word.
  assign R_INC = !R_RST && !EMPTY && (state_q == StAccum) && !FLUSH && !(last_lane && !ofree);

  // acc with the head entry written into the current lane.
  always_comb begin
    acc_wr = acc_q;
    for (int i = 0; i < int'(PACK); i++) begin
      if (idx_q == IdxW'(i)) begin
        acc_wr[i*width +: width] = RD_DATA;
      end
    end
  end

  assign keep_partial = lane_keep(32'(idx_q));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    flush_go  = 1'b0;
    load      = 1'b0;
    load_data = acc_q;
    load_keep = '0;

    if (R_INC) begin
      if (last_lane) begin
        load      = 1'b1;
        load_data = acc_wr;
        load_keep = '1;
        idx_d     = '0;
        acc_d     = '0;
      end else begin
        acc_d = acc_wr;
        idx_d = idx_q + IdxW'(1);
      end
    end

    // FLUSH blocks popping, so a flush never coincides with a pop.
    unique case (state_q)
      StAccum: begin
        if (FLUSH && (idx_q != '0)) begin
          if (ofree) begin
            flush_go = 1'b1;
          end else begin
            state_d = StFlushWait;
          end
        end
      end
      StFlushWait: begin
        if (ofree) begin
          flush_go = 1'b1;
          state_d  = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase

    if (flush_go) begin
      load      = 1'b1;
      load_data = acc_q;
      load_keep = keep_partial[PACK-1:0];
      idx_d     = '0;
      acc_d     = '0;
    end
  end

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      state_q <= StAccum;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  fifo_out_reg #(
    .DataW (DataW),
    .KeepW (PACK)
  ) u_out_reg (
    .clk_i   (R_CLK),
    .rst_i   (R_RST),
    .load_i  (load),
    .data_i  (load_data),
    .keep_i  (load_keep),
    .ready_i (OUT_READY),
    .valid_o (OUT_VALID),
    .data_o  (OUT_DATA),
    .keep_o  (OUT_KEEP)
  );

endmodule
